// File: rtl/fc_tile_scheduler.sv
// fc_tile_scheduler: sequences a tiled fully connected layer over a PE_COUNT-wide MAC array,
// one tile of neurons at a time (bias load, MAC stream, pipeline drain, result serialisation).
module fc_tile_scheduler #(
  parameter int unsigned IFM_DEPTH   = 120,
  parameter int unsigned NUM_NEURONS = 84,
  parameter int unsigned PE_COUNT    = 12,
  parameter int unsigned PIPE_LAT    = 2,
  localparam int unsigned NUM_TILES  = (NUM_NEURONS + PE_COUNT - 1) / PE_COUNT,
  localparam int unsigned IFM_AW     = $clog2(IFM_DEPTH),
  localparam int unsigned WM_AW      = $clog2(IFM_DEPTH * NUM_TILES),
  localparam int unsigned OFM_AW     = $clog2(NUM_NEURONS),
  localparam int unsigned LANE_W     = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
  localparam int unsigned TILE_W     = $clog2(NUM_TILES) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_from_previous,
  output logic                end_to_previous,
  output logic                ifm_rd_en,
  output logic [IFM_AW-1:0]   ifm_rd_addr,
  output logic                wm_rd_en,
  output logic [WM_AW-1:0]    wm_rd_addr,
  output logic [TILE_W-1:0]   tile_idx,
  output logic                bias_sel,
  output logic                acc_en,
  output logic                ofm_wr_en,
  output logic [OFM_AW-1:0]   ofm_wr_addr,
  output logic [LANE_W-1:0]   ofm_lane_sel,
  output logic                start_to_next,
  input  logic                end_from_next,
  output logic                busy
);

  localparam int unsigned D_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_HANDOFF
  } state_t;

  state_t              state, state_d;
  logic [IFM_AW-1:0]   k, k_d;
  logic [D_W-1:0]      d, d_d;
  logic [LANE_W-1:0]   j, j_d;
  logic [TILE_W-1:0]   tile_d;
  logic [PIPE_LAT-1:0] acc_pipe, bias_pipe;
  logic                stn_d;

  logic [31:0] tile_base;
  logic [31:0] lanes;
  logic        k_last, d_last, j_last, tile_last;

  // Lane count of the current tile; the final tile may be partial.
  always_comb begin
    tile_base = 32'(tile_idx) * PE_COUNT;
    lanes     = (NUM_NEURONS - tile_base < PE_COUNT) ? (NUM_NEURONS - tile_base) : PE_COUNT;
    k_last    = (32'(k) == IFM_DEPTH - 1);
    d_last    = (32'(d) == PIPE_LAT - 1);
    j_last    = (32'(j) == lanes - 1);
    tile_last = (32'(tile_idx) == NUM_TILES - 1);
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    d_d     = d;
    j_d     = j;
    tile_d  = tile_idx;
    stn_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_from_previous) begin
          tile_d  = '0;
          state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_last) begin
          d_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k + IFM_AW'(1);
        end
      end
      S_DRAIN: begin
        if (d_last) begin
          j_d     = '0;
          state_d = S_WRITE;
        end else begin
          d_d = d + D_W'(1);
        end
      end
      S_WRITE: begin
        if (j_last) begin
          if (tile_last) begin
            stn_d   = 1'b1;
            state_d = S_HANDOFF;
          end else begin
            tile_d  = tile_idx + TILE_W'(1);
            state_d = S_BIAS;
          end
        end else begin
          j_d = j + LANE_W'(1);
        end
      end
      S_HANDOFF: begin
        if (end_from_next) begin
          if (start_from_previous) begin
            tile_d  = '0;
            state_d = S_BIAS;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      k             <= '0;
      d             <= '0;
      j             <= '0;
      tile_idx      <= '0;
      start_to_next <= 1'b0;
    end else begin
      state         <= state_d;
      k             <= k_d;
      d             <= d_d;
      j             <= j_d;
      tile_idx      <= tile_d;
      start_to_next <= stn_d;
    end
  end

  // Delay the accumulate/bias qualifiers to line up with operands arriving at the MACs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_pipe  <= '0;
      bias_pipe <= '0;
    end else begin
      acc_pipe  <= (acc_pipe << 1)  | PIPE_LAT'((state == S_BIAS) || (state == S_MAC));
      bias_pipe <= (bias_pipe << 1) | PIPE_LAT'(state == S_BIAS);
    end
  end

  always_comb begin
    acc_en          = acc_pipe[PIPE_LAT-1];
    bias_sel        = bias_pipe[PIPE_LAT-1];
    busy            = (state != S_IDLE);
    end_to_previous = (state == S_IDLE) || (state == S_HANDOFF);
    ifm_rd_en       = (state == S_MAC);
    wm_rd_en        = (state == S_MAC);
    ifm_rd_addr     = '0;
    wm_rd_addr      = '0;
    ofm_wr_en       = (state == S_WRITE);
    ofm_wr_addr     = '0;
    ofm_lane_sel    = '0;
    if (state == S_MAC) begin
      ifm_rd_addr = k;
      wm_rd_addr  = WM_AW'(32'(tile_idx) * IFM_DEPTH + 32'(k));
    end
    if (state == S_WRITE) begin
      ofm_wr_addr  = OFM_AW'(tile_base + 32'(j));
      ofm_lane_sel = j;
    end
  end

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Scoreboard bench for fc_tile_scheduler: a small configuration for timing/handshake scenarios
// and a default-parameter instance for full-layer totals.
`timescale 1ns/1ps
module tb_fc_tile_scheduler;

  localparam int unsigned IFM_DEPTH = 4, NUM_NEURONS = 10, PE_COUNT = 4, PIPE_LAT = 2;
  localparam int unsigned NT     = (NUM_NEURONS + PE_COUNT - 1) / PE_COUNT;
  localparam int unsigned IFM_AW = $clog2(IFM_DEPTH);
  localparam int unsigned WM_AW  = $clog2(IFM_DEPTH * NT);
  localparam int unsigned OFM_AW = $clog2(NUM_NEURONS);
  localparam int unsigned LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int unsigned TILE_W = $clog2(NT) + 1;

  localparam int unsigned D_IFM_AW = $clog2(120);
  localparam int unsigned D_WM_AW  = $clog2(120 * 7);
  localparam int unsigned D_OFM_AW = $clog2(84);
  localparam int unsigned D_LANE_W = $clog2(12);
  localparam int unsigned D_TILE_W = $clog2(7) + 1;

  typedef struct { int cyc; int a; int b; } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic              start_from_previous, end_from_next;
  logic              end_to_previous, ifm_rd_en, wm_rd_en, bias_sel, acc_en;
  logic              ofm_wr_en, start_to_next, busy;
  logic [IFM_AW-1:0] ifm_rd_addr;
  logic [WM_AW-1:0]  wm_rd_addr;
  logic [TILE_W-1:0] tile_idx;
  logic [OFM_AW-1:0] ofm_wr_addr;
  logic [LANE_W-1:0] ofm_lane_sel;

  fc_tile_scheduler #(.IFM_DEPTH(IFM_DEPTH), .NUM_NEURONS(NUM_NEURONS),
                      .PE_COUNT(PE_COUNT), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset),
    .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .wm_rd_en(wm_rd_en), .wm_rd_addr(wm_rd_addr),
    .tile_idx(tile_idx), .bias_sel(bias_sel), .acc_en(acc_en),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_lane_sel(ofm_lane_sel),
    .start_to_next(start_to_next), .end_from_next(end_from_next), .busy(busy)
  );

  // default-parameter instance
  logic                dft_start, dft_end;
  logic                dft_etp, dft_ifm_en, dft_wm_en, dft_bias, dft_acc;
  logic                dft_wr_en, dft_stn, dft_busy;
  logic [D_IFM_AW-1:0] dft_ifm_addr;
  logic [D_WM_AW-1:0]  dft_wm_addr;
  logic [D_TILE_W-1:0] dft_tile;
  logic [D_OFM_AW-1:0] dft_wr_addr;
  logic [D_LANE_W-1:0] dft_lane;

  fc_tile_scheduler dut_dft (
    .clk(clk), .reset(reset),
    .start_from_previous(dft_start), .end_to_previous(dft_etp),
    .ifm_rd_en(dft_ifm_en), .ifm_rd_addr(dft_ifm_addr),
    .wm_rd_en(dft_wm_en), .wm_rd_addr(dft_wm_addr),
    .tile_idx(dft_tile), .bias_sel(dft_bias), .acc_en(dft_acc),
    .ofm_wr_en(dft_wr_en), .ofm_wr_addr(dft_wr_addr), .ofm_lane_sel(dft_lane),
    .start_to_next(dft_stn), .end_from_next(dft_end), .busy(dft_busy)
  );

  ev_t rd_q[$], acc_q[$], wr_q[$];
  int  stn_q[$], dwr_q[$];
  int  stn_cnt = 0, stn_at = 0;
  int  ep_lo = 1, ep_hi = 0;
  int  d_acc_cnt = 0, d_last_wm = -1, d_wr_cnt = 0, d_stn_cnt = 0, d_stn_at = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event timeline of one pass starting with BIAS at 'base'; events at or past 'cutoff' are dropped.
  task automatic push_pass(input int base, input int cutoff);
    int s;
    s = base;
    for (int t = 0; t < int'(NT); t++) begin
      int l;
      l = (int'(NUM_NEURONS) - t * int'(PE_COUNT) < int'(PE_COUNT)) ?
          int'(NUM_NEURONS) - t * int'(PE_COUNT) : int'(PE_COUNT);
      for (int k = 0; k < int'(IFM_DEPTH); k++)
        if (s + 1 + k < cutoff) rd_q.push_back('{s + 1 + k, t * int'(IFM_DEPTH) + k, k});
      for (int a = 0; a <= int'(IFM_DEPTH); a++)
        if (s + 2 + a < cutoff) acc_q.push_back('{s + 2 + a, (a == 0) ? 1 : 0, 0});
      for (int j = 0; j < l; j++)
        if (s + 7 + j < cutoff) wr_q.push_back('{s + 7 + j, t * int'(PE_COUNT) + j, j});
      s += 1 + int'(IFM_DEPTH) + int'(PIPE_LAT) + l;
    end
    if (s < cutoff) stn_q.push_back(s);
    ep_lo = base;
    ep_hi = (s - 1 < cutoff - 1) ? s - 1 : cutoff - 1;
  endtask

  // Monitor for the small instance: pops expectations whenever an output event appears.
  initial begin : mon_small
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (ifm_rd_en || wm_rd_en) begin
          if (rd_q.size() == 0) check("rd_unexpected", cyc, -1);
          else begin
            ev = rd_q.pop_front();
            check("rd_cycle", cyc, ev.cyc);
            check("wm_rd_addr", int'(wm_rd_addr), ev.a);
            check("ifm_rd_addr", int'(ifm_rd_addr), ev.b);
            check("ifm_rd_en", int'(ifm_rd_en), 1);
            check("wm_rd_en", int'(wm_rd_en), 1);
          end
        end
        if (acc_en) begin
          if (acc_q.size() == 0) check("acc_unexpected", cyc, -1);
          else begin
            ev = acc_q.pop_front();
            check("acc_cycle", cyc, ev.cyc);
            check("bias_sel", int'(bias_sel), ev.a);
          end
        end else begin
          check("bias_sel_without_acc", int'(bias_sel), 0);
        end
        if (ofm_wr_en) begin
          if (wr_q.size() == 0) check("wr_unexpected", cyc, -1);
          else begin
            ev = wr_q.pop_front();
            check("wr_cycle", cyc, ev.cyc);
            check("ofm_wr_addr", int'(ofm_wr_addr), ev.a);
            check("ofm_lane_sel", int'(ofm_lane_sel), ev.b);
          end
        end
        if (start_to_next) begin
          if (stn_q.size() == 0) check("stn_unexpected", cyc, -1);
          else check("stn_cycle", cyc, stn_q.pop_front());
          stn_at = cyc;
          stn_cnt++;
        end
        if (cyc >= ep_lo && cyc <= ep_hi) check("end_to_previous_in_pass", int'(end_to_previous), 0);
      end
    end
  end

  // Monitor for the default instance.
  initial begin : mon_dft
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (dft_acc) d_acc_cnt++;
        if (dft_wm_en) d_last_wm = int'(dft_wm_addr);
        if (dft_wr_en) begin
          d_wr_cnt++;
          if (dwr_q.size() == 0) check("dft_wr_unexpected", cyc, -1);
          else check("dft_ofm_wr_addr", int'(dft_wr_addr), dwr_q.pop_front());
        end
        if (dft_stn) begin
          d_stn_at = cyc;
          d_stn_cnt++;
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_stn(input int limit, output int at);
    int n0;
    int i;
    n0 = stn_cnt;
    i  = 0;
    while (stn_cnt == n0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (stn_cnt == n0) begin
      check("stn_timeout", 0, 1);
      at = -1;
    end else begin
      at = stn_at;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_end_to_previous"}, int'(end_to_previous), 1);
    check({tag, "_ifm_rd_en"}, int'(ifm_rd_en), 0);
    check({tag, "_wm_rd_en"}, int'(wm_rd_en), 0);
    check({tag, "_wm_rd_addr"}, int'(wm_rd_addr), 0);
    check({tag, "_ifm_rd_addr"}, int'(ifm_rd_addr), 0);
    check({tag, "_acc_en"}, int'(acc_en), 0);
    check({tag, "_bias_sel"}, int'(bias_sel), 0);
    check({tag, "_ofm_wr_en"}, int'(ofm_wr_en), 0);
    check({tag, "_ofm_wr_addr"}, int'(ofm_wr_addr), 0);
    check({tag, "_tile_idx"}, int'(tile_idx), 0);
    check({tag, "_start_to_next"}, int'(start_to_next), 0);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_acc_left"}, acc_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
    check({tag, "_stn_left"}, stn_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int at;
    int i;
    reset = 1'b0;
    start_from_previous = 1'b0;
    end_from_next = 1'b0;
    dft_start = 1'b0;
    dft_end = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single pass with ignored starts in MAC and WRITE
    base = cyc + 1;
    push_pass(base, 1 << 30);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    wait_cyc(base + 2);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    wait_cyc(base + 8);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    wait_stn(60, at);
    check("pass1_latency", at - base, 31);
    check("handoff_end_to_previous", int'(end_to_previous), 1);
    check("handoff_busy", int'(busy), 1);

    // hold in HANDOFF, then back-to-back restart
    repeat (10) @(negedge clk);
    check("handoff_hold_busy", int'(busy), 1);
    check_queues("pass1");
    base = cyc + 1;
    push_pass(base, 1 << 30);
    end_from_next = 1'b1;
    start_from_previous = 1'b1;
    @(negedge clk);
    end_from_next = 1'b0;
    start_from_previous = 1'b0;
    check("b2b_tile_idx", int'(tile_idx), 0);
    check("b2b_busy", int'(busy), 1);
    check("b2b_end_to_previous", int'(end_to_previous), 0);
    wait_stn(60, at);
    check("pass2_latency", at - base, 31);
    end_from_next = 1'b1;
    @(negedge clk);
    end_from_next = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_end_to_previous", int'(end_to_previous), 1);
    check_queues("pass2");

    // reset while k=2 in tile 1
    base = cyc + 1;
    push_pass(base, base + 15);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    wait_cyc(base + 14);
    check("pre_reset_tile_idx", int'(tile_idx), 1);
    check("pre_reset_ifm_rd_addr", int'(ifm_rd_addr), 2);
    reset = 1'b0;
    #1;
    check_reset_outputs("midmac");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_busy", int'(busy), 0);
    check_queues("aborted");

    base = cyc + 1;
    push_pass(base, 1 << 30);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    wait_stn(60, at);
    check("pass3_latency", at - base, 31);
    end_from_next = 1'b1;
    @(negedge clk);
    end_from_next = 1'b0;
    check_queues("pass3");

    // default parameters: full layer
    for (int a = 0; a < 84; a++) dwr_q.push_back(a);
    base = cyc + 1;
    dft_start = 1'b1;
    @(negedge clk);
    dft_start = 1'b0;
    check("dft_busy", int'(dft_busy), 1);
    i = 0;
    while (d_stn_cnt == 0 && i < 1200) begin
      @(negedge clk);
      i++;
    end
    check("dft_stn_seen", d_stn_cnt, 1);
    check("dft_latency", d_stn_at - base, 945);
    check("dft_acc_cycles", d_acc_cnt, 847);
    check("dft_last_wm_rd_addr", d_last_wm, 839);
    check("dft_wr_pulses", d_wr_cnt, 84);
    check("dft_wr_left", dwr_q.size(), 0);
    dft_end = 1'b1;
    @(negedge clk);
    dft_end = 1'b0;
    check("dft_idle", int'(dft_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_tile_scheduler.md
Name: fc_tile_scheduler

Overview:
- Sequences a fully connected layer whose output neurons are computed PE_COUNT at a time on a parallel MAC array.
- For each tile of neurons it:
  - loads the biases,
  - streams the IFM_DEPTH input activations and the matching weight rows,
  - drains the MAC pipeline,
  - serialises the PE_COUNT results into the next layer's buffer.
- Handshakes with the previous layer (start_from_previous / end_to_previous) and the next layer (start_to_next / end_from_next).

Parameters:
- IFM_DEPTH, 120, input vector length (MAC iterations per tile)
- NUM_NEURONS, 84, output neurons in the layer
- PE_COUNT, 12, parallel MAC lanes
- PIPE_LAT, 2, cycles from a read strobe to operands at the MAC inputs (>=1)
- NUM_TILES, ceil(NUM_NEURONS/PE_COUNT), derived
- IFM_AW, $clog2(IFM_DEPTH), derived
- WM_AW, $clog2(IFM_DEPTH*NUM_TILES), derived
- OFM_AW, $clog2(NUM_NEURONS), derived
- LANE_W, max(1,$clog2(PE_COUNT)), derived

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- start_from_previous  in  1  input vector is valid in the IFM buffer.
- end_to_previous  out  1  1 = IFM buffer may be overwritten.
- ifm_rd_en  out  1  IFM buffer read strobe.
- ifm_rd_addr  out  IFM_AW  IFM read address.
- wm_rd_en  out  1  weight memory read strobe.
- wm_rd_addr  out  WM_AW  weight row address.
- tile_idx  out  $clog2(NUM_TILES)+1  current tile; selects the bias bank.
- bias_sel  out  1  MAC array loads bias instead of accumulating.
- acc_en  out  1  MAC array update enable.
- ofm_wr_en  out  1  next-layer buffer write strobe.
- ofm_wr_addr  out  OFM_AW  neuron index being written.
- ofm_lane_sel  out  LANE_W  MAC lane multiplexed onto the write data.
- start_to_next  out  1  one-cycle pulse: output vector complete.
- end_from_next  in  1  next layer has consumed the output vector.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, BIAS, MAC, DRAIN, WRITE, HANDOFF. Outputs are Moore-decoded from registered state and counters.
- Counters:
  - k: 0..IFM_DEPTH-1
  - d: 0..PIPE_LAT-1
  - j: 0..L-1, where L = min(PE_COUNT, NUM_NEURONS - tile_idx*PE_COUNT); the last tile may be partial.
  - tile_idx: 0..NUM_TILES-1
- IDLE:
  - end_to_previous=1.
  - On start_from_previous=1: tile_idx<=0 and go to BIAS.
  - start_from_previous is ignored in every other state except HANDOFF.
- BIAS: one cycle; k<=0; go to MAC.
- MAC:
  - ifm_rd_en=wm_rd_en=1, ifm_rd_addr=k, wm_rd_addr=tile_idx*IFM_DEPTH+k; k increments.
  - At k=IFM_DEPTH-1: d<=0 and go to DRAIN.
- DRAIN: PIPE_LAT cycles, no strobes; then j<=0 and go to WRITE.
- WRITE:
  - ofm_wr_en=1, ofm_lane_sel=j, ofm_wr_addr=tile_idx*PE_COUNT+j.
  - At j=L-1: if tile_idx=NUM_TILES-1 go to HANDOFF; else tile_idx++ and go to BIAS.
- HANDOFF:
  - end_to_previous=1, because all IFM reads are complete.
  - On end_from_next=1: go to IDLE. If start_from_previous=1 in the same cycle, go directly to BIAS with tile_idx=0.
- end_to_previous=0 in BIAS, MAC, DRAIN and WRITE.
- Alignment pipe:
  - acc_en = (state==BIAS | state==MAC) delayed PIPE_LAT cycles.
  - bias_sel = (state==BIAS) delayed PIPE_LAT cycles.
  - Per tile this gives exactly IFM_DEPTH+1 acc_en cycles, the first with bias_sel=1.
  - Both bits retire before WRITE begins, because DRAIN lasts PIPE_LAT cycles.
- start_to_next:
  - Registered; high exactly in the first HANDOFF cycle.
  - Never high for more than one cycle per layer pass.
- Latency:
  - Each tile takes 1+IFM_DEPTH+PIPE_LAT+L cycles.
  - With default parameters: 7 tiles x 135 cycles, so start_to_next rises 945 cycles after the first BIAS cycle.
- Address arithmetic:
  - Performed at full width, then truncated to the port width.
  - No address ever exceeds IFM_DEPTH*NUM_TILES-1 or NUM_NEURONS-1.
- Reset (reset=0, at any time, including mid-MAC):
  - state=IDLE; all counters and tile_idx=0; delay pipes cleared.
  - All strobes, bias_sel, acc_en and start_to_next=0; all addresses=0; busy=0; end_to_previous=1.
  - No stray acc_en or ofm_wr_en pulse may appear after release.

Test Plan:
Scenarios 1–4 use IFM_DEPTH=4, NUM_NEURONS=10, PE_COUNT=4, PIPE_LAT=2.
- Single pass:
  - Stimulus: 1-cycle start_from_previous in IDLE.
  - Required: wm_rd_addr sequences 0-3, 4-7, 8-11; ofm_wr_addr sequences 0-3, 4-7, 8-9 (partial tile, ofm_lane_sel 0-1); start_to_next pulses 31 cycles after the first BIAS cycle; end_to_previous=0 throughout.
- Alignment:
  - Check: per tile, acc_en is high for 5 cycles starting 2 cycles after BIAS; bias_sel=1 only on the first of them; acc_en=0 in every WRITE cycle.
- Back-to-back:
  - Stimulus: hold end_from_next=0 for 10 cycles in HANDOFF, then assert end_from_next and start_from_previous together.
  - Required: state goes to BIAS with tile_idx=0; a second start_to_next appears 31 cycles later.
- Reset mid-MAC:
  - Stimulus: drive reset=0 while k=2 in tile 1, then release.
  - Required: all outputs take their reset values immediately; no acc_en or ofm_wr_en afterwards until a new start; a fresh start produces a full 31-cycle pass.
- Defaults:
  - Stimulus: default parameters, one start.
  - Required: 84 ofm_wr_en pulses (addresses 0-83), 847 acc_en cycles, last wm_rd_addr=839, start_to_next at cycle 945.
- Ignored start:
  - Stimulus: assert start_from_previous during MAC or WRITE.
  - Required: no effect on counters or state.
